// File: rtl/random_prog_loader.sv
// random_prog_loader: packs a 32-bit word stream into 56-bit program RAM entries, then launches
// random_math and waits for its ack. Define PROG_CHECK_EN to turn illegal instructions into RET.
module random_prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int NREG   = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prog_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [55:0]       ram_wdata,
  output logic              exec_start,
  input  logic              exec_ack,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0]        OP_RET    = 8'd6;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        NREG_B    = 8'(NREG);

  typedef enum logic [1:0] {S_LO, S_HI, S_START, S_EXEC} state_t;

  state_t            state_reg;
  logic [31:0]       word0_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic [7:0] op_code;
  logic [7:0] dst_index;
  logic [7:0] src_index;
  logic [7:0] op_written;
  logic       illegal;
  logic       force_ret;
  logic       last_instr;
  logic       accept;
  logic       unused_bits;

  assign op_code   = in_data[23:16];
  assign dst_index = in_data[15:8];
  assign src_index = in_data[7:0];

  assign in_ready = ((state_reg == S_LO) || (state_reg == S_HI)) && !prog_clear;
  assign busy     = (state_reg != S_LO);
  assign accept   = in_valid && in_ready;

`ifdef PROG_CHECK_EN
  assign illegal = (op_code > OP_RET) || (dst_index >= NREG_B) || (src_index >= NREG_B);
`else
  assign illegal = 1'b0;
`endif

  // The last RAM slot must hold a RET so the executor can never run off the end.
  assign force_ret  = illegal || ((addr_reg == LAST_ADDR) && (op_code != OP_RET));
  assign op_written = force_ret ? OP_RET : op_code;
  assign last_instr = (op_written == OP_RET);

  assign unused_bits = ^{in_data[31:24], NREG_B};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_LO;
      word0_reg  <= '0;
      addr_reg   <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      exec_start <= 1'b0;
      prog_done  <= 1'b0;
      prog_len   <= '0;
      err        <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      exec_start <= 1'b0;
      prog_done  <= 1'b0;
      if (prog_clear) begin
        state_reg <= S_LO;
        addr_reg  <= '0;
        prog_len  <= '0;
        err       <= 1'b0;
      end else begin
        case (state_reg)
          S_LO: begin
            if (accept) begin
              word0_reg <= in_data;
              state_reg <= S_HI;
            end
          end
          S_HI: begin
            if (accept) begin
              ram_we    <= 1'b1;
              ram_waddr <= addr_reg;
              ram_wdata <= {op_written, dst_index, src_index, word0_reg};
              prog_len  <= {1'b0, addr_reg} + {{ADDR_W{1'b0}}, 1'b1};
              if (force_ret) begin
                err <= 1'b1;
              end
              if (last_instr) begin
                state_reg <= S_START;
              end else begin
                addr_reg  <= addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_reg <= S_LO;
              end
            end
          end
          S_START: begin
            exec_start <= 1'b1;
            state_reg  <= S_EXEC;
          end
          S_EXEC: begin
            if (exec_ack) begin
              prog_done <= 1'b1;
              addr_reg  <= '0;
              state_reg <= S_LO;
            end
          end
          default: state_reg <= S_LO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_prog_loader.sv
// Testbench for random_prog_loader: randomized word streams checked against a program-level
// reference model of what the RAM should receive.
module tb_random_prog_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int NREG   = 9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              prog_clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [55:0]       ram_wdata;
  logic              exec_start;
  logic              exec_ack = 1'b0;
  logic              prog_done;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              err;

  random_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk(clk), .reset_n(reset_n), .prog_clear(prog_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .exec_start(exec_start), .exec_ack(exec_ack), .prog_done(prog_done),
    .prog_len(prog_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed RAM writes and control pulses, sampled mid-cycle.
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [55:0]       wr_data_q[$];
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cnt  = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        wr_addr_q.push_back(ram_waddr);
        wr_data_q.push_back(ram_wdata);
      end
      if (exec_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (prog_done) done_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: the program to send and the sticky error flag.
  logic [31:0] prog_w0[$];
  logic [31:0] prog_w1[$];
  bit err_model = 1'b0;

  function automatic logic [31:0] mk_w1(input logic [7:0] op);
    logic [7:0] hi, d, s;
    hi = 8'($urandom);
    d  = 8'($urandom_range(NREG - 1, 0));
    s  = 8'($urandom_range(NREG - 1, 0));
    return {hi, op, d, s};
  endfunction

  task automatic send_word(input logic [31:0] w, input int max_gap, output int acc);
    int k;
    repeat ($urandom_range(max_gap, 0)) tick();
    in_valid = 1'b1;
    in_data  = w;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) check_val("in_ready_stall", {63'd0, in_ready}, 64'd1);
    acc = cyc;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic load_and_check(input string tag, input int max_gap);
    logic [ADDR_W-1:0] ea[$];
    logic [55:0]       ed[$];
    logic [7:0]        op, wop;
    bit                bad;
    int                n_send, acc, s0, k, n;
    n_send = prog_w0.size();
    acc = 0;
    for (int i = 0; i < prog_w0.size(); i++) begin
      op  = prog_w1[i][23:16];
      bad = 1'b0;
`ifdef PROG_CHECK_EN
      bad = (int'(op) > 6) || (int'(prog_w1[i][15:8]) >= NREG) || (int'(prog_w1[i][7:0]) >= NREG);
`endif
      if (i == DEPTH - 1 && op != 8'd6) bad = 1'b1;
      wop = bad ? 8'd6 : op;
      ea.push_back(ADDR_W'(i));
      ed.push_back({wop, prog_w1[i][15:0], prog_w0[i]});
      if (bad) err_model = 1'b1;
      if (wop == 8'd6) begin
        n_send = i + 1;
        break;
      end
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    s0 = start_cnt;
    for (int i = 0; i < n_send; i++) begin
      send_word(prog_w0[i], max_gap, acc);
      send_word(prog_w1[i], max_gap, acc);
    end
    k = 0;
    while (start_cnt == s0 && k < 10) begin
      tick();
      k++;
    end
    check_val({tag, " exec_start_count"}, 64'(start_cnt - s0), 64'd1);
    check_val({tag, " start_latency"}, 64'(start_cyc - acc), 64'd2);
    check_val({tag, " write_count"}, 64'(wr_addr_q.size()), 64'(ea.size()));
    n = (wr_addr_q.size() < ea.size()) ? wr_addr_q.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
        check_val($sformatf("%s wr%0d_addr", tag, i), 64'(wr_addr_q[i]), 64'(ea[i]));
        check_val($sformatf("%s wr%0d_data", tag, i), 64'(wr_data_q[i]), 64'(ed[i]));
      end
    end
    if (n > 0) begin
      check_val({tag, " last_wr_addr"}, 64'(wr_addr_q[n-1]), 64'(ea[n-1]));
      check_val({tag, " last_wr_data"}, 64'(wr_data_q[n-1]), 64'(ed[n-1]));
    end
    check_val({tag, " prog_len"}, 64'(prog_len), 64'(n_send));
    check_val({tag, " err"}, 64'(err), 64'(err_model));
    check_val({tag, " in_ready_exec"}, 64'(in_ready), 64'd0);
    check_val({tag, " busy_exec"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_exec(input string tag, input int delay);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (cyc < start_cyc + delay && k < 100) begin
      tick();
      k++;
    end
    exec_ack = 1'b1;
    tick();
    exec_ack = 1'b0;
    check_val({tag, " prog_done"}, 64'(prog_done), 64'd1);
    check_val({tag, " busy_idle"}, 64'(busy), 64'd0);
    check_val({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    tick();
    check_val({tag, " prog_done_pulse"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    logic [31:0] a0, b0, a1, b1, a2, b2;
    int d0, r, len;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst ram_we", 64'(ram_we), 64'd0);
    check_val("rst exec_start", 64'(exec_start), 64'd0);
    check_val("rst err", 64'(err), 64'd0);
    check_val("rst prog_len", 64'(prog_len), 64'd0);
    check_val("rst busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    tick();
    check_val("rst in_ready", 64'(in_ready), 64'd1);
    check_val("rst prog_done", 64'(prog_done), 64'd0);

    // Two-instruction program ending in RET
    prog_w0 = '{32'h11223344, 32'h00000000};
    prog_w1 = '{32'h00010203, 32'h00060000};
    load_and_check("t1", 0);
    if (wr_data_q.size() >= 2) begin
      check_val("t1 data0", 64'(wr_data_q[0]), 64'h0001020311223344);
      check_val("t1 data1", 64'(wr_data_q[1]), 64'h0006000000000000);
    end
    finish_exec("t2", 5);

    // Overflow: 128 non-RET instructions
    prog_w0.delete();
    prog_w1.delete();
    for (int i = 0; i < DEPTH; i++) begin
      prog_w0.push_back($urandom);
      prog_w1.push_back(mk_w1(8'd1));
    end
    load_and_check("t3", 0);
    finish_exec("t3", 3);

    // prog_clear while word1 of the third instruction is offered
    a0 = $urandom; b0 = mk_w1(8'd1);
    a1 = $urandom; b1 = mk_w1(8'd2);
    a2 = $urandom; b2 = mk_w1(8'd3);
    wr_addr_q.delete();
    wr_data_q.delete();
    send_word(a0, 0, r); send_word(b0, 0, r);
    send_word(a1, 0, r); send_word(b1, 0, r);
    send_word(a2, 0, r);
    in_valid = 1'b1;
    in_data = b2;
    prog_clear = 1'b1;
    #1;
    check_val("t4 in_ready_clear", 64'(in_ready), 64'd0);
    tick();
    prog_clear = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    err_model = 1'b0;
    check_val("t4 write_count", 64'(wr_addr_q.size()), 64'd2);
    if (wr_data_q.size() >= 2) begin
      check_val("t4 wr0_data", 64'(wr_data_q[0]), 64'({b0[23:0], a0}));
      check_val("t4 wr1_addr", 64'(wr_addr_q[1]), 64'd1);
    end
    check_val("t4 prog_len", 64'(prog_len), 64'd0);
    check_val("t4 err", 64'(err), 64'd0);
    check_val("t4 busy", 64'(busy), 64'd0);
    prog_w0 = '{a2, 32'h0};
    prog_w1 = '{mk_w1(8'd4), mk_w1(8'd6)};
    load_and_check("t4b", 1);
    finish_exec("t4b", 2);

    // Out-of-range dst index
    prog_w0 = '{$urandom, $urandom, $urandom, $urandom};
    prog_w1 = '{mk_w1(8'd2), 32'h00010902, mk_w1(8'd3), mk_w1(8'd6)};
    load_and_check("t5", 0);
    finish_exec("t5", 1);

    // Random programs, random gaps, exec_ack held while idle
    for (int it = 0; it < 6; it++) begin
      d0 = done_cnt;
      exec_ack = 1'b1;
      repeat ($urandom_range(8, 3)) tick();
      exec_ack = 1'b0;
      tick();
      check_val($sformatf("t6.%0d no_spurious_done", it), 64'(done_cnt - d0), 64'd0);
      prog_w0.delete();
      prog_w1.delete();
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        prog_w0.push_back($urandom);
        prog_w1.push_back((i == len - 1) ? mk_w1(8'd6) : $urandom);
      end
      load_and_check($sformatf("t6.%0d", it), 3);
      finish_exec($sformatf("t6.%0d", it), $urandom_range(4, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
